sevenseg_scan: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-segment 7-seg display.

---
 rtl/sevenseg_scan_pkg.sv | 28 ++
 rtl/sevenseg_scan_seg_decode.sv | 20 ++
 rtl/sevenseg_scan.sv | 244 ++++++++++++++++++++++++
 tb/tb_sevenseg_scan.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_scan_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_pkg
// Shared types and constants for the seven-segment scan controller.
//   scan_state_e : scan FSM states (OFF, SHOW, BLANK)
//   SEG_BLANK    : all segments dark
//   SEG_LUT      : hex nibble -> {g,f,e,d,c,b,a}, active high
//   seg_lookup() : table lookup helper used by the shared decoder
// -----------------------------------------------------------------------------
package sevenseg_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] nibble);
        return SEG_LUT[nibble];
    endfunction

endpackage

// File: rtl/sevenseg_scan_seg_decode.sv
// -----------------------------------------------------------------------------
// seg_decode
// Combinational hex-to-seven-segment decoder; one instance is shared by all
// digits of the scan controller.
//   nibble : 4-bit hex value
//   seg    : segments {g,f,e,d,c,b,a}, active high
// -----------------------------------------------------------------------------
module seg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for the selected nibble.
    always_comb begin
        seg = seg_lookup(nibble);
    end

endmodule

// File: rtl/sevenseg_scan.sv
// -----------------------------------------------------------------------------
// sevenseg_scan
// Time-multiplexed scan controller for an N-digit common-segment display.
// A one-hot digit enable walks across the digits, each lit for DWELL_CYC
// cycles, separated by BLANK_CYC dark cycles. New values arrive through a
// valid/ready handshake into a pending buffer and are moved into the display
// buffer only at a frame start, so a frame never mixes two values.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   en_i         scan enable; low forces the display dark
//   upd_valid_i  new value offered; upd_ready_o high while pending buffer empty
//   upd_value_i  hex nibbles, digit 0 in bits [3:0]
//   dig_en_o     one-hot digit enable (all-zero when dark)
//   seg_o        segments {g..a}; seg_n_o is its complement
//   frame_o      pulse on the first lit cycle of digit 0
//
// Configuration macro
//   SEVENSEG_SCAN_LZB_EN : leading-zero blanking of digits above digit 0.
//
// All outputs are registered: the next-cycle values are computed from the
// next-state signals and captured on the same edge as the state itself.
// -----------------------------------------------------------------------------
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int DWELL_CYC = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  upd_valid_i,
    output logic                  upd_ready_o,
    input  logic [4*N_DIGITS-1:0] upd_value_i,
    output logic [N_DIGITS-1:0]   dig_en_o,
    output logic [6:0]            seg_o,
    output logic [6:0]            seg_n_o,
    output logic                  frame_o
);

    localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(N_DIGITS);
    localparam int VAL_W   = 4 * N_DIGITS;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    // With no blanking gap the BLANK state is unreachable; keep a legal value.
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};

    scan_state_e          state_r, state_s;
    logic [IDX_W-1:0]     idx_r, idx_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [VAL_W-1:0]     disp_r, disp_s;
    logic [VAL_W-1:0]     pend_r, pend_s;
    logic                 pend_full_r, pend_full_s;
    logic                 frame_start_s;
    logic                 accept_s;
    logic [3:0]           nibble_s;
    logic [6:0]           dec_seg_s;
    logic [6:0]           seg_s;
    logic [N_DIGITS-1:0]  dig_en_s;
    logic                 lzb_s;

    logic [N_DIGITS-1:0]  dig_en_r;
    logic [6:0]           seg_r;
    logic [6:0]           seg_n_r;
    logic                 frame_r;
    logic                 ready_r;

    // Scan FSM next state: digit index, dwell/blank counter, frame-start detect.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        cnt_s         = cnt_r;
        frame_start_s = 1'b0;
        if (!en_i) begin
            state_s = OFF;
            idx_s   = IDX_ZERO;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                OFF: begin
                    state_s       = SHOW;
                    idx_s         = IDX_ZERO;
                    cnt_s         = CNT_ZERO;
                    frame_start_s = 1'b1;
                end
                SHOW: begin
                    if (cnt_r == DWELL_LAST) begin
                        cnt_s = CNT_ZERO;
                        if (idx_r == IDX_LAST) begin
                            idx_s = IDX_ZERO;
                        end else begin
                            idx_s = idx_r + IDX_W'(1);
                        end
                        if (BLANK_CYC > 0) begin
                            state_s = BLANK;
                        end else begin
                            // Straight back into SHOW: a wrap is a frame start.
                            state_s       = SHOW;
                            frame_start_s = (idx_s == IDX_ZERO);
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_s       = SHOW;
                        cnt_s         = CNT_ZERO;
                        frame_start_s = (idx_r == IDX_ZERO);
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s = OFF;
                    idx_s   = IDX_ZERO;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Double buffer: pending value moves to display only at frame start.
    // The swap needs pend full and the accept needs pend empty, so they never
    // collide; an offer while full waits one edge after the swap.
    always_comb begin
        accept_s    = upd_valid_i && !pend_full_r;
        disp_s      = disp_r;
        pend_s      = pend_r;
        pend_full_s = pend_full_r;
        if (frame_start_s && pend_full_r) begin
            disp_s      = pend_r;
            pend_full_s = 1'b0;
        end else begin
            disp_s = disp_r;
        end
        if (accept_s) begin
            pend_s      = upd_value_i;
            pend_full_s = 1'b1;
        end else begin
            pend_s = pend_r;
        end
    end

    // Select the active nibble and digit enable for the upcoming cycle.
    always_comb begin
        nibble_s = 4'h0;
        dig_en_s = {N_DIGITS{1'b0}};
        for (int k = 0; k < N_DIGITS; k++) begin
            if (IDX_W'(k) == idx_s) begin
                nibble_s    = disp_s[4*k +: 4];
                dig_en_s[k] = (state_s == SHOW);
            end else begin
                dig_en_s[k] = 1'b0;
            end
        end
    end

`ifdef SEVENSEG_SCAN_LZB_EN
    // Leading-zero mask: digit k>0 is dark if it and every higher nibble are 0.
    always_comb begin
        logic hi_zero;
        hi_zero = 1'b1;
        lzb_s   = 1'b0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            hi_zero = hi_zero && (disp_s[4*k +: 4] == 4'h0);
            if (IDX_W'(k) == idx_s) begin
                lzb_s = hi_zero;
            end else begin
                lzb_s = lzb_s;
            end
        end
    end
`else
    // Every digit is decoded, leading zeros included.
    always_comb begin
        lzb_s = 1'b0;
    end
`endif

    seg_decode u_seg_decode (
        .nibble (nibble_s),
        .seg    (dec_seg_s)
    );

    // Segment pattern for the upcoming cycle: dark outside SHOW or when masked.
    always_comb begin
        if ((state_s == SHOW) && !lzb_s) begin
            seg_s = dec_seg_s;
        end else begin
            seg_s = SEG_BLANK;
        end
    end

    // Scan state and buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= OFF;
            idx_r       <= IDX_ZERO;
            cnt_r       <= CNT_ZERO;
            disp_r      <= {VAL_W{1'b0}};
            pend_r      <= {VAL_W{1'b0}};
            pend_full_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            cnt_r       <= cnt_s;
            disp_r      <= disp_s;
            pend_r      <= pend_s;
            pend_full_r <= pend_full_s;
        end
    end

    // Output registers, loaded in step with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_en_r <= {N_DIGITS{1'b0}};
            seg_r    <= SEG_BLANK;
            seg_n_r  <= 7'h7F;
            frame_r  <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            dig_en_r <= dig_en_s;
            seg_r    <= seg_s;
            seg_n_r  <= ~seg_s;
            frame_r  <= frame_start_s;
            ready_r  <= !pend_full_s;
        end
    end

    assign dig_en_o    = dig_en_r;
    assign seg_o       = seg_r;
    assign seg_n_o     = seg_n_r;
    assign frame_o     = frame_r;
    assign upd_ready_o = ready_r;

endmodule

// File: tb/tb_sevenseg_scan.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan
// Two instances (blank gap 2 and no gap) share the stimulus. A position-in-frame
// model predicts every output each cycle; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan;

    localparam int ND  = 4;
    localparam int DW  = 4;
    localparam int BL0 = 2;
    localparam int BL1 = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] value = 16'h0000;

    logic       ready0, frame0, ready1, frame1;
    logic [3:0] dig0, dig1;
    logic [6:0] seg0, segn0, seg1, segn1;

    always #5 clk = ~clk;

    sevenseg_scan #(.N_DIGITS(ND), .DWELL_CYC(DW), .BLANK_CYC(BL0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en_i(en), .upd_valid_i(valid),
        .upd_ready_o(ready0), .upd_value_i(value), .dig_en_o(dig0),
        .seg_o(seg0), .seg_n_o(segn0), .frame_o(frame0)
    );

    sevenseg_scan #(.N_DIGITS(ND), .DWELL_CYC(DW), .BLANK_CYC(BL1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en_i(en), .upd_valid_i(valid),
        .upd_ready_o(ready1), .upd_value_i(value), .dig_en_o(dig1),
        .seg_o(seg1), .seg_n_o(segn1), .frame_o(frame1)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // ---------------- behavioural model (per instance) ----------------
    bit          m_on    [2];
    int          m_pos   [2];   // cycle position within the frame, 0 = frame start
    bit          m_fs    [2];
    bit          m_pfull [2];
    logic [15:0] m_pend  [2];
    logic [15:0] m_disp  [2];

    function automatic int slot_of(input int i);
        return DW + ((i == 0) ? BL0 : BL1);
    endfunction

    function automatic int period_of(input int i);
        return ND * slot_of(i);
    endfunction

    function automatic bit starts(input int i);
        return en && (!m_on[i] || ((m_pos[i] + 1) % period_of(i)) == 0);
    endfunction

    function automatic logic [3:0] exp_dig(input int i);
        if (m_on[i] && (m_pos[i] % slot_of(i)) < DW) return 4'(1 << (m_pos[i] / slot_of(i)));
        else return 4'b0000;
    endfunction

    function automatic logic [6:0] exp_seg(input int i);
        int d;
        logic [15:0] sh;
        if (exp_dig(i) == 4'b0000) return 7'h00;
        d  = m_pos[i] / slot_of(i);
        sh = m_disp[i] >> (4 * d);
`ifdef SEVENSEG_SCAN_LZB_EN
        if (d > 0 && sh == 16'h0000) return 7'h00;
`endif
        return lut[sh[3:0]];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_on[i] <= 1'b0; m_pos[i] <= 0; m_fs[i] <= 1'b0;
                m_pfull[i] <= 1'b0; m_pend[i] <= 16'h0000; m_disp[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!en) begin
                    m_on[i] <= 1'b0; m_pos[i] <= 0;
                end else if (!m_on[i]) begin
                    m_on[i] <= 1'b1; m_pos[i] <= 0;
                end else begin
                    m_pos[i] <= (m_pos[i] + 1) % period_of(i);
                end
                m_fs[i] <= starts(i);
                if (starts(i) && m_pfull[i]) begin
                    m_disp[i] <= m_pend[i]; m_pfull[i] <= 1'b0;
                end
                if (valid && !m_pfull[i]) begin
                    m_pend[i] <= value; m_pfull[i] <= 1'b1;
                end
            end
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        chk("dig0",   int'(dig0),   int'(exp_dig(0)));
        chk("seg0",   int'(seg0),   int'(exp_seg(0)));
        chk("segn0",  int'(segn0),  int'(7'(~exp_seg(0))));
        chk("frame0", int'(frame0), int'(m_fs[0]));
        chk("ready0", int'(ready0), int'(!m_pfull[0]));
        chk("dig1",   int'(dig1),   int'(exp_dig(1)));
        chk("seg1",   int'(seg1),   int'(exp_seg(1)));
        chk("segn1",  int'(segn1),  int'(7'(~exp_seg(1))));
        chk("frame1", int'(frame1), int'(m_fs[1]));
        chk("ready1", int'(ready1), int'(!m_pfull[1]));
    end

    // ---------------- directed + random stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame0 && k < 100);
        chk("wait_frame", int'(frame0), 1);
    endtask

    int t1_cyc [8] = '{0, 3, 4, 6, 11, 12, 18, 21};
    int t1_dig [8] = '{1, 1, 0, 2, 0, 4, 8, 8};
    int t1_seg [8] = '{'h66, 'h66, 0, 'h4F, 0, 'h5B, 'h06, 'h06};

    initial begin
        int c, dark_cnt, change_cnt;
        logic [3:0] prev;
        int z;

        step(3);
        rst_n = 1'b1;
        step(2);
        chk("rst_dig",   int'(dig0),   0);
        chk("rst_seg",   int'(seg0),   0);
        chk("rst_segn",  int'(segn0),  'h7F);
        chk("rst_ready", int'(ready0), 1);

        // Load while OFF, then enable: walk through one frame.
        valid = 1'b1; value = 16'h1234;
        step(1);
        valid = 1'b0; en = 1'b1;
        step(1);
        chk("t1_frame", int'(frame0), 1);
        c = 0;
        for (int j = 0; j < 8; j++) begin
            step(t1_cyc[j] - c);
            c = t1_cyc[j];
            chk("t1_dig", int'(dig0), t1_dig[j]);
            chk("t1_seg", int'(seg0), t1_seg[j]);
        end
        step(24 - c);
        chk("t1_period", int'(frame0), 1);

        // Offer mid-frame, then a second value held while not ready.
        step(2);
        chk("t2_ready_before", int'(ready0), 1);
        valid = 1'b1; value = 16'hABCD;
        step(1);
        chk("t2_ready_drop", int'(ready0), 0);
        value = 16'h00EF;
        wait_frame();
        chk("t2_abcd_shown", int'(seg0), 'h5E);
        chk("t2_ready_at_frame", int'(ready0), 1);
        step(1);
        chk("t2_ef_accepted", int'(ready0), 0);
        valid = 1'b0;
        wait_frame();
        chk("t2_ef_digit0", int'(seg0), 'h71);
        step(6);
        chk("t2_ef_digit1", int'(seg0), 'h79);

        // Disable mid-SHOW of digit 2, then re-enable.
        wait_frame();
        step(13);
        chk("t4_digit2", int'(dig0), 4);
        en = 1'b0;
        step(1);
        chk("t4_dark_dig", int'(dig0), 0);
        chk("t4_dark_seg", int'(seg0), 0);
        step(2);
        en = 1'b1;
        step(1);
        chk("t4_resume_frame", int'(frame0), 1);
        chk("t4_resume_dig", int'(dig0), 1);
        chk("t4_resume_seg", int'(seg0), 'h71);

        // Fill pend, then asynchronous reset between clock edges.
        valid = 1'b1; value = 16'h9876;
        step(1);
        valid = 1'b0;
        chk("t5_pend_full", int'(ready0), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_dig",   int'(dig0),   0);
        chk("t5_rst_seg",   int'(seg0),   0);
        chk("t5_rst_segn",  int'(segn0),  'h7F);
        chk("t5_rst_frame", int'(frame0), 0);
        chk("t5_rst_ready", int'(ready0), 1);
        step(1);

        // Release with an offer on the same edge as the frame start: no bypass.
        rst_n = 1'b1; valid = 1'b1; value = 16'h0050;
        step(1);
        valid = 1'b0;
        chk("t6_frame", int'(frame0), 1);
        chk("t6_no_bypass", int'(seg0), 'h3F);
        chk("t6_pend_full", int'(ready0), 0);
        wait_frame();
        chk("t6_digit0", int'(seg0), 'h3F);
        step(6);
        chk("t6_digit1", int'(seg0), 'h6D);
        step(6);
`ifdef SEVENSEG_SCAN_LZB_EN
        chk("t6_digit2", int'(seg0), 'h00);
`else
        chk("t6_digit2", int'(seg0), 'h3F);
`endif
        step(6);
`ifdef SEVENSEG_SCAN_LZB_EN
        chk("t6_digit3", int'(seg0), 'h00);
`else
        chk("t6_digit3", int'(seg0), 'h3F);
`endif

        // No-gap instance: never dark while enabled, rotates every DW cycles.
        dark_cnt = 0; change_cnt = 0;
        prev = dig1;
        for (int j = 0; j < 40; j++) begin
            step(1);
            if ($countones(dig1) != 1) dark_cnt++;
            if (dig1 != prev) change_cnt++;
            prev = dig1;
        end
        chk("t3_never_dark", dark_cnt, 0);
        chk("t3_rotations", change_cnt, 10);

        // Random traffic against the model.
        for (int j = 0; j < 3000; j++) begin
            en    = ($urandom_range(0, 99) != 0);
            valid = ($urandom_range(0, 2) == 0);
            z     = $urandom_range(0, 4);
            value = 16'($urandom) >> (4 * z);
            step(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
